// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants, state enum and length check for the imem boot loader
package imem_loader_pkg;

    localparam int         DEPTH     = 1024;
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    function automatic logic len_legal(input logic [15:0] len);
        return (len != 16'd0) && (len <= 16'(DEPTH));
    endfunction

endpackage

// File: rtl/imem_loader_le_word_packer.sv
// rtl/imem_loader_le_word_packer.sv - assembles four bytes into one little-endian 32-bit word
module le_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d = 2'd0;
        end else if (byte_valid) begin
            cnt_d   = cnt_q + 2'd1;
            // earlier bytes drift toward the low lanes as later ones arrive
            shift_d = {byte_data, shift_q[23:8]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid = byte_valid && !clear && (cnt_q == 2'd3);
    assign word_data  = {byte_data, shift_q};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART-fed instruction memory writer holding the core in reset until loaded
// Optional trailing checksum byte enabled by defining LOADER_CSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          core_hold,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   words_loaded
);

    loader_state_e state_q, state_d;
    logic [7:0]    len_lo_q, len_lo_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   words_q, words_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          frame_start;
    logic [15:0]   len16;
    logic          word_valid;
    logic [31:0]   word_data;
`ifdef LOADER_CSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    assign len16 = {rx_data, len_lo_q};

    le_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (frame_start),
        .byte_valid (rx_valid && (state_q == ST_DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        words_d     = words_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        frame_start = 1'b0;
`ifdef LOADER_CSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d     = ST_LEN_LO;
                    frame_start = 1'b1;
                    words_d     = '0;
`ifdef LOADER_CSUM_EN
                    csum_d      = 8'd0;
`endif
                end
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    len_lo_d = rx_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid) begin
                    if (len_legal(len16)) begin
                        len_d   = len16[AW:0];
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DATA: begin
`ifdef LOADER_CSUM_EN
                if (rx_valid) csum_d = csum_q + rx_data;
`endif
                if (word_valid) begin
                    we_d    = 1'b1;
                    wdata_d = word_data;
                    waddr_d = words_q[AW-1:0];
                    words_d = words_q + 1'b1;
                    if (words_q == len_q - 1'b1) begin
`ifdef LOADER_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef LOADER_CSUM_EN
            ST_CSUM: begin
                if (rx_valid) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            len_lo_q <= 8'd0;
            len_q    <= '0;
            words_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            words_q  <= words_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
`ifdef LOADER_CSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;
    assign core_hold    = (state_q != ST_DONE);
    assign load_done    = (state_q == ST_DONE);
    assign load_err     = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed and randomized frame checks of imem_loader against a byte-level model
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    int n_cmp = 0;
    int n_err = 0;
    int we_count = 0;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_we === 1'b1) we_count <= we_count + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_status(input string tag, input bit done, input bit err);
        chk({tag, ".done"}, load_done, done);
        chk({tag, ".err"},  load_err,  err);
        chk({tag, ".hold"}, core_hold, !done);
    endtask

    // Sends one frame; expectations are derived from the frame contents alone.
    task automatic send_frame(input string tag, input int len16, input logic [7:0] data[$],
                              input bit bad_csum, input int gap_max);
        logic [7:0]  sum;
        logic [31:0] exp_word;
        int          we_before;
        sum = 8'd0;
        send(SYNC_BYTE);
        chk({tag, ".hold_after_sync"}, core_hold, 1'b1);
        chk({tag, ".words_clr"}, words_loaded, '0);
        send(len16[7:0]);
        send(len16[15:8]);
        if (len16 < 1 || len16 > DEPTH) begin
            we_before = we_count;
            chk_status({tag, ".len_err"}, 1'b0, 1'b1);
            chk({tag, ".len_err_we"}, imem_we, 1'b0);
            idle(2);
            chk({tag, ".len_err_nowrite"}, we_count, we_before);
            return;
        end
        for (int j = 0; j < data.size(); j++) begin
            idle($urandom_range(0, gap_max));
            send(data[j]);
            sum += data[j];
            if (j % 4 == 3) begin
                exp_word = {data[j], data[j-1], data[j-2], data[j-3]};
                chk({tag, ".we"},    imem_we, 1'b1);
                chk({tag, ".waddr"}, imem_waddr, j / 4);
                chk({tag, ".wdata"}, imem_wdata, exp_word);
                chk({tag, ".words"}, words_loaded, j / 4 + 1);
            end else if (j < 8 || j + 8 > data.size()) begin
                chk({tag, ".we_low"}, imem_we, 1'b0);
            end
        end
`ifdef LOADER_CSUM_EN
        chk_status({tag, ".pre_csum"}, 1'b0, 1'b0);
        send(bad_csum ? sum + 8'd1 : sum);
        chk_status({tag, ".end"}, !bad_csum, bad_csum);
`else
        chk_status({tag, ".end"}, 1'b1, 1'b0);
`endif
        chk({tag, ".words_final"}, words_loaded, len16);
    endtask

    logic [7:0] q[$];
    int         len;
    logic [7:0] g;

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        idle(2);
        chk("rst.we", imem_we, 1'b0);
        chk("rst.waddr", imem_waddr, '0);
        chk("rst.wdata", imem_wdata, 32'd0);
        chk("rst.words", words_loaded, '0);
        chk_status("rst", 1'b0, 1'b0);
        reset = 1'b0;
        idle(1);

        send(8'h55);
        send(8'h13);
        chk_status("garbage", 1'b0, 1'b0);
        chk("garbage.words", words_loaded, '0);
        q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h05, 8'h00, 8'h20};
        send_frame("basic", 2, q, 1'b0, 0);
        chk("basic.const_word1", imem_wdata, 32'h200005B7);

        send(8'h00);
        send(8'h13);
        chk_status("done_ignore", 1'b1, 1'b0);
        q = '{8'h6F, 8'hF0, 8'h9F, 8'hFF};
        send_frame("restart", 1, q, 1'b0, 0);
        chk("restart.const", imem_wdata, 32'hFF9FF06F);

        q = {};
        send_frame("len0", 0, q, 1'b0, 0);
        send_frame("len401", 16'h0401, q, 1'b0, 0);
        send_frame("lenffff", 16'hFFFF, q, 1'b0, 0);

`ifdef LOADER_CSUM_EN
        q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h05, 8'h00, 8'h20};
        send_frame("badcsum", 2, q, 1'b1, 0);
`endif

        send(SYNC_BYTE);
        send(8'h02);
        send(8'h00);
        send(8'h13);
        send(8'h00);
        #2 reset = 1'b1;
        #1;
        chk("midrst.we", imem_we, 1'b0);
        chk("midrst.waddr", imem_waddr, '0);
        chk("midrst.wdata", imem_wdata, 32'd0);
        chk("midrst.words", words_loaded, '0);
        chk_status("midrst", 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h05, 8'h00, 8'h20};
        send_frame("after_rst", 2, q, 1'b0, 0);

        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom);
                if (g == SYNC_BYTE) g = 8'h00;
                send(g);
            end
            len = $urandom_range(1, 6);
            q = {};
            for (int k = 0; k < len * 4; k++) q.push_back(8'($urandom));
            send_frame("rand", len, q, 1'b0, (f % 2) ? 2 : 0);
        end

        q = {};
        for (int k = 0; k < DEPTH * 4; k++) q.push_back(8'($urandom));
        send_frame("full", DEPTH, q, 1'b0, 0);
        chk("full.last_addr", imem_waddr, DEPTH - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
